// File: rtl/prog_sequencer.sv
// ============================================================================
// Module      : prog_sequencer
// Description : Program-launch controller. Detects Start edges, selects the
//               program base address, loads it into the PC, gates PC advance
//               while a program runs and reports Done / CycleCount / Err.
//               Optional watchdog enabled by defining PROG_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_sequencer #(
  parameter int A       = 10,
  parameter int NPROG   = 3,
  parameter int STRIDE  = 100,
  parameter int TIMEOUT = 4096
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         HaltInst,
  output logic         PcLoad,
  output logic [A-1:0] PcLoadVal,
  output logic         PcEn,
  output logic         Done,
  output logic [1:0]   ProgNum,
  output logic [15:0]  CycleCount,
  output logic         Err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]   c_nprog  = 2'(NPROG);
  localparam logic [A-1:0] c_stride = A'(STRIDE);
`ifdef PROG_WATCHDOG_EN
  localparam logic [15:0]  c_timeout = 16'(TIMEOUT);
`endif

  // Reject out-of-range configurations at elaboration.
  if (NPROG < 1 || NPROG > 3 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("prog_sequencer: NPROG must be 1..3 and TIMEOUT 1..65535");
  end

  state_t      r_state, w_state_nxt;
  logic        r_start_q;
  logic        r_done, w_done_nxt;
  logic [1:0]  r_prog, w_prog_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_err, w_err_nxt;

  logic        w_rise, w_fall, w_has_next;
  logic [15:0] w_cnt_sat;
  logic [A-1:0] w_idx, w_base;

  assign w_rise     = Start & ~r_start_q;
  assign w_fall     = ~Start & r_start_q;
  assign w_has_next = (r_prog < c_nprog);
  assign w_cnt_sat  = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);

  // Base address is computed at PC width; overflow simply truncates.
  assign w_idx  = A'(r_prog) - A'(1);
  assign w_base = A'(w_idx * c_stride);

  // State and status registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_done    <= 1'b0;
      r_prog    <= 2'd0;
      r_cnt     <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= Start;
      r_done    <= w_done_nxt;
      r_prog    <= w_prog_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state and register-update logic; a rise always takes priority.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    w_prog_nxt  = r_prog;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_rise) begin
          if (w_has_next) begin
            w_prog_nxt  = r_prog + 2'd1;
            w_done_nxt  = 1'b0;
            w_state_nxt = S_ARMED;
          end else begin
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ARMED: begin
        if (w_fall) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt_nxt   = 16'd0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Every RUN cycle counts, including halt and abort cycles.
        w_cnt_nxt = w_cnt_sat;
        if (w_rise) begin
          if (w_has_next) begin
            w_prog_nxt  = r_prog + 2'd1;
            w_done_nxt  = 1'b0;
            w_state_nxt = S_ARMED;
          end else begin
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else if (HaltInst) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end
`ifdef PROG_WATCHDOG_EN
        else if (w_cnt_sat == c_timeout) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign PcLoad     = (r_state == S_LOAD);
  assign PcLoadVal  = (r_state == S_LOAD) ? w_base : '0;
  // Combinational gate so the PC stays parked on the halt instruction.
  assign PcEn       = (r_state == S_RUN) & ~HaltInst;
  assign Done       = r_done;
  assign ProgNum    = r_prog;
  assign CycleCount = r_cnt;
  assign Err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// ============================================================================
// Module      : tb_prog_sequencer
// Description : Directed self-checking bench for prog_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        HaltInst;
  logic        PcLoad;
  logic [9:0]  PcLoadVal;
  logic        PcEn;
  logic        Done;
  logic [1:0]  ProgNum;
  logic [15:0] CycleCount;
  logic        Err;

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt = 0;
  int en_cnt   = 0;
  logic [9:0] load_val = '0;

  prog_sequencer #(
    .A(10), .NPROG(3), .STRIDE(100), .TIMEOUT(50)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .HaltInst(HaltInst),
    .PcLoad(PcLoad), .PcLoadVal(PcLoadVal), .PcEn(PcEn), .Done(Done),
    .ProgNum(ProgNum), .CycleCount(CycleCount), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Observe load pulses and PC-advance cycles mid-cycle.
  always @(negedge Clk) begin
    if (PcLoad === 1'b1) begin
      load_cnt = load_cnt + 1;
      load_val = PcLoadVal;
    end
    if (PcEn === 1'b1) en_cnt = en_cnt + 1;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; HaltInst = 1'b0;
    step(); step();
    Reset = 1'b0;
  endtask

  // Start pulse of 3 cycles; returns in the LOAD cycle.
  task automatic launch();
    Start = 1'b1;
    step(); step(); step();
    Start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if ({PcEn, PcLoad, Done, ProgNum, Err, CycleCount, PcLoadVal} !== '0)
        $display("FAIL reset_idle[%0d]: PcEn=%0b PcLoad=%0b Done=%0b ProgNum=%0d Err=%0b Cyc=%0d Val=%0d expected all 0",
                 i, PcEn, PcLoad, Done, ProgNum, Err, CycleCount, PcLoadVal);
      else n_pass++;
    end
  endtask

  task automatic run_program(input int n, input logic [9:0] base, input int halt_at);
    Start = 1'b1;
    step();
    n_checks++;
    if (ProgNum !== 2'(n) || Done !== 1'b0 || PcEn !== 1'b0)
      $display("FAIL rise_p%0d: ProgNum=%0d Done=%0b PcEn=%0b expected %0d 0 0", n, ProgNum, Done, PcEn, n);
    else n_pass++;
    step(); step();
    Start = 1'b0;
    load_cnt = 0;
    en_cnt   = 0;
    step();
    n_checks++;
    if (PcLoad !== 1'b1 || PcLoadVal !== base || PcEn !== 1'b0)
      $display("FAIL load_p%0d: PcLoad=%0b PcLoadVal=%0d PcEn=%0b expected 1 %0d 0", n, PcLoad, PcLoadVal, PcEn, base);
    else n_pass++;
    for (int i = 1; i <= halt_at; i++) begin
      step();
      if (i == halt_at) HaltInst = 1'b1;
    end
    #1;
    n_checks++;
    if (PcEn !== 1'b0)
      $display("FAIL halt_gate_p%0d: PcEn=%0b expected 0", n, PcEn);
    else n_pass++;
    step();
    HaltInst = 1'b0;
    #1;
    n_checks++;
    if (Done !== 1'b1 || CycleCount !== 16'(halt_at) || PcEn !== 1'b0)
      $display("FAIL done_p%0d: Done=%0b Cyc=%0d PcEn=%0b expected 1 %0d 0", n, Done, CycleCount, PcEn, halt_at);
    else n_pass++;
    n_checks++;
    if (load_cnt !== 1 || load_val !== base || en_cnt !== halt_at - 1)
      $display("FAIL pulses_p%0d: loads=%0d val=%0d en_cycles=%0d expected 1 %0d %0d",
               n, load_cnt, load_val, en_cnt, base, halt_at - 1);
    else n_pass++;
  endtask

  task automatic test_programs();
    run_program(1, 10'd0, 20);
    run_program(2, 10'd100, 7);
    run_program(3, 10'd200, 3);
  endtask

  task automatic test_overflow();
    load_cnt = 0;
    Start = 1'b1;
    step();
    n_checks++;
    if (Err !== 1'b1 || Done !== 1'b1 || ProgNum !== 2'd3)
      $display("FAIL overflow: Err=%0b Done=%0b ProgNum=%0d expected 1 1 3", Err, Done, ProgNum);
    else n_pass++;
    step(); step();
    Start = 1'b0;
    step(); step(); step();
    n_checks++;
    if (load_cnt !== 0 || PcEn !== 1'b0 || ProgNum !== 2'd3 || Done !== 1'b1 || Err !== 1'b1)
      $display("FAIL overflow_hold: loads=%0d PcEn=%0b ProgNum=%0d Done=%0b Err=%0b expected 0 0 3 1 1",
               load_cnt, PcEn, ProgNum, Done, Err);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    launch();
    for (int i = 0; i < 50; i++) step();
    n_checks++;
    if (PcEn !== 1'b1 || Done !== 1'b0)
      $display("FAIL run50: PcEn=%0b Done=%0b expected 1 0", PcEn, Done);
    else n_pass++;
`ifdef PROG_WATCHDOG_EN
    step();
    n_checks++;
    if (Done !== 1'b1 || Err !== 1'b1 || CycleCount !== 16'd50 || PcEn !== 1'b0)
      $display("FAIL watchdog: Done=%0b Err=%0b Cyc=%0d PcEn=%0b expected 1 1 50 0", Done, Err, CycleCount, PcEn);
    else n_pass++;
`else
    for (int i = 0; i < 150; i++) step();
    n_checks++;
    if (PcEn !== 1'b1 || Done !== 1'b0 || Err !== 1'b0 || CycleCount !== 16'd199)
      $display("FAIL no_watchdog: PcEn=%0b Done=%0b Err=%0b Cyc=%0d expected 1 0 0 199", PcEn, Done, Err, CycleCount);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    launch();
    for (int i = 0; i < 5; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_checks++;
    if ({PcEn, PcLoad, Done, ProgNum, Err, CycleCount, PcLoadVal} !== '0)
      $display("FAIL reset_mid: PcEn=%0b PcLoad=%0b Done=%0b ProgNum=%0d Err=%0b Cyc=%0d Val=%0d expected all 0",
               PcEn, PcLoad, Done, ProgNum, Err, CycleCount, PcLoadVal);
    else n_pass++;
    en_cnt = 0;
    step(); step();
    n_checks++;
    if (en_cnt !== 0 || PcEn !== 1'b0)
      $display("FAIL reset_idle_after: en_cycles=%0d PcEn=%0b expected 0 0", en_cnt, PcEn);
    else n_pass++;
  endtask

  task automatic test_rise_with_halt();
    do_reset();
    launch();
    for (int i = 0; i < 6; i++) step();
    Start = 1'b1;
    HaltInst = 1'b1;
    step();
    HaltInst = 1'b0;
    #1;
    n_checks++;
    if (Done !== 1'b0 || ProgNum !== 2'd2 || PcEn !== 1'b0 || CycleCount !== 16'd6)
      $display("FAIL rise_halt: Done=%0b ProgNum=%0d PcEn=%0b Cyc=%0d expected 0 2 0 6", Done, ProgNum, PcEn, CycleCount);
    else n_pass++;
    Start = 1'b0;
    step();
    n_checks++;
    if (PcLoad !== 1'b1 || PcLoadVal !== 10'd100)
      $display("FAIL rise_halt_load: PcLoad=%0b PcLoadVal=%0d expected 1 100", PcLoad, PcLoadVal);
    else n_pass++;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; HaltInst = 1'b0;
    test_reset();
    test_programs();
    test_overflow();
    test_timeout();
    test_reset_mid_run();
    test_rise_with_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_sequencer.md
# prog_sequencer

Program-launch controller that sits between the testbench Start handshake and the program counter. It detects Start edges and selects the program base address. It loads that address into the PC and gates PC advance while a program runs. It detects completion from the decoder's halt indication and reports Done, cycle count and error status back to the testbench.

## Interface
- A, default 10: instruction-memory address width; matches the PC width.
- NPROG, default 3: number of programs; legal range 1–3.
- STRIDE, default 100: address spacing between program bases. Program n (1-based) starts at (n-1)*STRIDE.
- TIMEOUT, default 4096: watchdog limit in RUN cycles; legal range 1–65535. Used only with the macro.
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; forces IDLE and clears all registers.
- Start  in  1  testbench request level; a program launches on its falling edge.
- HaltInst  in  1  decoder flag: the instruction at the current PC is the halt/done instruction.
- PcLoad  out  1  one-cycle pulse: the PC loads PcLoadVal on the next edge.
- PcLoadVal  out  A  load address; valid whenever PcLoad=1.
- PcEn  out  1  PC advance enable; 0 freezes the PC.
- Done  out  1  level; the current program has finished.
- ProgNum  out  2  index of the current program, 1..NPROG; 0 before the first Start.
- CycleCount  out  16  number of RUN cycles in the current or last program.
- Err  out  1  sticky error flag.

## Operation
- Edge detect: start_r is a registered copy of Start.
  - rise = Start & ~start_r.
  - fall = ~Start & start_r.
- States and transitions:
  - IDLE: rise -> ARMED.
  - ARMED: fall -> LOAD.
  - LOAD: always -> RUN.
  - RUN: HaltInst -> DONE; rise -> ARMED (abort); watchdog expiry -> DONE.
  - DONE: rise -> ARMED.
- Rise handling in IDLE, RUN and DONE:
  - If ProgNum < NPROG: ProgNum increments, Done clears, state -> ARMED.
  - If ProgNum = NPROG: Err sets, Done sets, state -> DONE. ProgNum holds and no load follows.
- Outputs by state:
  - PcLoad = 1 only in LOAD.
  - PcLoadVal = (ProgNum-1)*STRIDE, computed at width A and truncated on overflow. It is 0 outside LOAD.
  - PcEn = (state==RUN) & ~HaltInst. This is combinational, so the PC stays on the halt instruction.
  - Done is registered: set on the RUN->DONE transition, cleared on the rise that leaves DONE.
- CycleCount:
  - Cleared in LOAD.
  - Increments on every RUN cycle, including the halt cycle.
  - Saturates at 16'hFFFF.
  - Holds in IDLE, ARMED and DONE.
- Simultaneous rise and HaltInst in RUN: the rise wins (abort -> ARMED). CycleCount still counts that cycle.
- Err clears only on Reset.
- Reset values: state IDLE, start_r 0, PcLoad 0, PcLoadVal 0, PcEn 0, Done 0, ProgNum 0, CycleCount 0, Err 0.
- Reset mid-operation: at any state, the next edge returns to IDLE with all outputs at reset values. The PC is not advanced by this block afterwards.

## Timing
- Fall sampled at edge k (Start=0, start_r=1): the state is LOAD after edge k and PcLoad is high for one cycle.
- The PC holds the base address after edge k+1. RUN starts in the same cycle, with the first fetch at the base address.
- HaltInst high in RUN cycle j: PcEn=0 in that same cycle. Done=1 and PcEn=0 from edge j+1.
- The PC never advances in IDLE, ARMED, LOAD or DONE.
- Err and Done from an overflow rise are visible one cycle after the rise edge.

## Configuration
- PROG_WATCHDOG_EN defined:
  - RUN exits to DONE on the edge where CycleCount would reach TIMEOUT without HaltInst, so RUN lasts exactly TIMEOUT cycles.
  - At that exit Done=1 and Err=1, and CycleCount=TIMEOUT.
- PROG_WATCHDOG_EN undefined:
  - No timeout; RUN lasts until HaltInst or an abort.
  - Err sets only on NPROG overflow.
  - The TIMEOUT parameter is ignored.

## Test plan
- Reset, then 10 idle cycles with Start=0 -> PcEn=0, PcLoad=0, Done=0, ProgNum=0, Err=0 throughout.
- Start high for 3 cycles then low; HaltInst on the 20th RUN cycle -> one PcLoad pulse with PcLoadVal=0 and ProgNum=1. PcEn=1 for 19 cycles, then Done=1 and CycleCount=20.
- Second and third Start pulses, each ended by HaltInst -> PcLoadVal=100 and then 200, ProgNum=2 and then 3. Done drops on each rise.
- Fourth Start pulse -> Err=1, Done=1, no PcLoad pulse, ProgNum stays 3.
- TIMEOUT=50, launch with no HaltInst:
  - Macro on: Done=1 and Err=1 after exactly 50 RUN cycles, CycleCount=50.
  - Macro off: still RUN with PcEn=1 after 200 cycles.
- Reset asserted for 1 cycle in RUN, and separately a rise together with HaltInst in RUN:
  - Reset: all outputs at reset values on the next cycle.
  - Rise with HaltInst: state ARMED, Done=0, ProgNum incremented.
